// File: rtl/fact_bcd_conv.sv
// rtl/fact_bcd_conv.sv - serial 16-bit binary to 5-digit packed BCD converter (double dabble)
module fact_bcd_conv (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] fact,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] sh_bin_q, sh_bin_d;
    logic [19:0] sh_bcd_q, sh_bcd_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [19:0] bcd_q, bcd_d;
    logic [19:0] bcd_adj;

    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q  <= IDLE;
            sh_bin_q <= 16'd0;
            sh_bcd_q <= 20'd0;
            cnt_q    <= 5'd0;
            bcd_q    <= 20'd0;
        end else begin
            state_q  <= state_d;
            sh_bin_q <= sh_bin_d;
            sh_bcd_q <= sh_bcd_d;
            cnt_q    <= cnt_d;
            bcd_q    <= bcd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CONV;
            CONV:    if (cnt_q == 5'd15) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Digits of 5..9 become 8..12 so the following shift carries into the next digit.
    always_comb begin
        bcd_adj = sh_bcd_q;
        for (int i = 0; i < 5; i++) begin
            if (sh_bcd_q[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = sh_bcd_q[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        sh_bin_d = sh_bin_q;
        sh_bcd_d = sh_bcd_q;
        cnt_d    = cnt_q;
        bcd_d    = bcd_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sh_bin_d = fact;
                    sh_bcd_d = 20'd0;
                    cnt_d    = 5'd0;
                end
            end
            CONV: begin
                sh_bcd_d = {bcd_adj[18:0], sh_bin_q[15]};
                sh_bin_d = {sh_bin_q[14:0], 1'b0};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd15)
                    bcd_d = {bcd_adj[18:0], sh_bin_q[15]};
            end
            default: ;
        endcase
    end

    always_comb begin
        busy = (state_q == CONV);
        done = (state_q == DONE);
        bcd  = bcd_q;
    end

endmodule

// File: tb/tb_fact_bcd_conv.sv
// tb/tb_fact_bcd_conv.sv - randomized self-checking bench for fact_bcd_conv
module tb_fact_bcd_conv;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] fact;
    logic        busy;
    logic        done;
    logic [19:0] bcd;

    int tests  = 0;
    int errors = 0;

    fact_bcd_conv dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .fact    (fact),
        .busy    (busy),
        .done    (done),
        .bcd     (bcd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] ref_bcd(input int v);
        logic [19:0] r;
        int          x;
        r = 20'd0;
        x = v;
        for (int d = 0; d < 5; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept a request, optionally inject a stray start or a reset mid-flight, and watch the outcome.
    task automatic run_conv(input int v, input int stray_at, input int stray_v, input int reset_at,
                            input logic [19:0] prev_bcd);
        int cycles;
        int busy_cnt;
        int done_cnt;
        start = 1'b1;
        fact  = 16'(v);
        tick();
        start = 1'b0;
        fact  = 16'($urandom_range(0, 65535));
        cycles   = 0;
        busy_cnt = 0;
        done_cnt = 0;
        while (!done && cycles < 40) begin
            if (busy) busy_cnt++;
            if (cycles == stray_at) begin
                start = 1'b1;
                fact  = 16'(stray_v);
            end else begin
                start = 1'b0;
            end
            reset_n = (cycles == reset_at);
            tick();
            cycles++;
            if (reset_at >= 0 && cycles == reset_at + 1) begin
                reset_n = 1'b0;
                check("reset_busy", 32'(busy), 32'd0);
                check("reset_bcd", 32'(bcd), 32'd0);
                for (int k = 0; k < 24; k++) begin
                    if (done) done_cnt++;
                    tick();
                end
                check("reset_no_done", 32'(done_cnt), 32'd0);
                return;
            end
            if (busy && done) check("busy_done_overlap", 32'd1, 32'd0);
            if (!done && !busy && cycles < 16) check("bcd_hold", 32'(bcd), 32'(prev_bcd));
        end
        check("latency", 32'(cycles), 32'd16);
        check("busy_cycles", 32'(busy_cnt), 32'd16);
        check($sformatf("bcd_%0d", v), 32'(bcd), 32'(ref_bcd(v)));
        tick();
        check("done_fall", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) tick();
        check("bcd_hold_idle", 32'(bcd), 32'(ref_bcd(v)));
    endtask

    initial begin
        int v;
        int cycles;
        int done_cnt;
        reset_n = 1'b1;
        start   = 1'b1;
        fact    = 16'd720;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd), 32'd0);
        reset_n = 1'b0;
        start   = 1'b0;
        tick();

        run_conv(720,   -1, 0, -1, 20'h00000);
        run_conv(40320, -1, 0, -1, 20'h00720);
        run_conv(0,     -1, 0, -1, 20'h40320);
        run_conv(65535, -1, 0, -1, 20'h00000);
        run_conv(9999,  -1, 0, -1, 20'h65535);
        run_conv(10000, -1, 0, -1, 20'h09999);
        run_conv(720,    4, 5040, -1, 20'h10000);
        run_conv(40320, -1, 0, 7, 20'h00720);
        run_conv(24,    -1, 0, -1, 20'h00000);

        // A start held high for several cycles must yield a single conversion.
        start = 1'b1;
        fact  = 16'd720;
        for (int k = 0; k < 3; k++) tick();
        start = 1'b0;
        done_cnt = 0;
        cycles = 0;
        while (cycles < 30) begin
            if (done) begin
                done_cnt++;
                check("held_start_bcd", 32'(bcd), 32'(ref_bcd(720)));
            end
            tick();
            cycles++;
        end
        check("held_start_done_count", 32'(done_cnt), 32'd1);

        v = 720;
        for (int n = 0; n < 20; n++) begin
            int nv;
            nv = $urandom_range(0, 65535);
            run_conv(nv, -1, 0, -1, ref_bcd(v));
            v = nv;
        end

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/fact_bcd_conv.md
# fact_bcd_conv

Sequential binary-to-BCD converter that sits directly downstream of the factorial engine. It captures the engine's 16-bit `fact` result when pulsed by the engine's `done`, and converts it to five packed BCD digits using iterative shift-and-add-3 (double dabble). The converter processes one bit per clock and drives a digit display or readout stage.

## Interface
Parameters: none; all widths are fixed.
- `clk` input 1: single clock; all logic updates on the rising edge.
- `reset_n` input 1: synchronous, active-high reset. Sampled high at a rising edge, it resets the block.
- `start` input 1: conversion request; normally wired to the factorial `done`. Sampled only in IDLE.
- `fact` input 16: unsigned binary value. Sampled on the same edge that accepts `start`.
- `busy` output 1: high while a conversion is in progress (CONV state).
- `done` output 1: one-cycle pulse that marks a new result on `bcd`.
- `bcd` output 20: packed BCD result. [19:16] is the ten-thousands digit; [3:0] is the units digit.

## Operation
- Internal registers:
  - `sh_bin[15:0]`: shift register for the binary input.
  - `sh_bcd[19:0]`: BCD accumulator.
  - `cnt[4:0]`: iteration counter.
  - `state` ∈ {IDLE, CONV, DONE}.
- IDLE:
  - With `start`=1 at an edge: `sh_bin`←`fact`, `sh_bcd`←0, `cnt`←0, state→CONV.
  - With `start`=0: remain in IDLE.
- CONV, one iteration per edge:
  - First, each 4-bit digit of `sh_bcd` that is ≥5 has 3 added to it.
  - Then `{sh_bcd, sh_bin}` shifts left by 1 as a 36-bit value.
  - `cnt`←`cnt`+1.
  - The iteration at which `cnt`=15 is the 16th and last. On that edge, `bcd`←the post-shift `sh_bcd`, `done`←1, state→DONE.
- DONE: `done`←0, state→IDLE. `start` is ignored in this state.
- `start` is ignored in CONV and DONE. A new request arriving then is dropped; it is not queued.
- Range: the full 16-bit input range 0–65535 is valid. The ten-thousands digit is at most 6, so no BCD overflow is possible. Digit adders are 4-bit; a digit value of 5–9 plus 3 never exceeds 12, so there is no carry between digits before the shift.
- `bcd` changes only on a completing edge. It holds its value through IDLE, through subsequent conversions, and until the next completion.
- Reset, including mid-conversion, takes effect at the edge where `reset_n`=1:
  - state→IDLE; `busy`=0, `done`=0, `bcd`=20'h00000; `sh_bin`, `sh_bcd`, `cnt` cleared.
  - Any conversion in progress is discarded and produces no `done` pulse.
  - Reset has priority over `start` on the same edge.

## Timing
- Reset values: `busy`=0, `done`=0, `bcd`=20'h00000, state=IDLE.
- Let edge N be the edge that accepts `start`:
  - `busy`=1 from after edge N through edge N+16.
  - Edges N+1 through N+16 perform the 16 iterations.
  - `bcd` is valid and `done`=1 during the cycle after edge N+16.
  - `done` falls after edge N+17.
- Latency: 16 clocks from the accepting edge to the `done` edge.
- Minimum `start` spacing: 18 clocks. The earliest next acceptance is edge N+18, when the block is back in IDLE.
- `busy` and `done` are never high in the same cycle.
- The outputs are registered; there are no combinational paths from input to output.
- Upstream coupling: the factorial engine's `done`-high cycle is sampled as `start`. If `done` stays high for several cycles, only the first edge in IDLE is accepted; a `done` still high when the block returns to IDLE retriggers a conversion.

## Test plan
- Reset, then a `start` pulse with `fact`=16'd720 (6!) → `done` at edge N+16 with `bcd`=20'h00720; `busy` high for exactly 16 cycles.
- `fact`=16'd40320 (8!) → `bcd`=20'h40320. Then `fact`=16'd0 → `bcd`=20'h00000, with `done` still pulsed.
- Boundary values:
  - `fact`=16'd65535 → `bcd`=20'h65535.
  - `fact`=16'd9999 → `bcd`=20'h09999 (exercises add-3 on every digit).
  - `fact`=16'd10000 → `bcd`=20'h10000.
- Start `fact`=720 at edge N; pulse `start` with `fact`=5040 at edge N+5 → the second request is ignored; the single `done` carries `bcd`=20'h00720.
- Start `fact`=40320; assert `reset_n` at edge N+8 → no `done` pulse; `busy`=0 and `bcd`=20'h00000 after that edge. A following `start` with `fact`=24 → `bcd`=20'h00024.
- Connect to the factorial engine with input 6 → after the engine's `done`, the converter's `done` pulses and `bcd`=20'h00720; the result holds until the next completion.
